// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock sequencer.
//   state_e    : FSM state encoding (also driven on the debug 'state' port)
//   DIR_*      : direction register values
//   is_eq_state: true for the two equalize phases
package airlock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EQ1   = 3'd1,
    DOOR1 = 3'd2,
    EQ2   = 3'd3,
    DOOR2 = 3'd4,
    FAULT = 3'd7
  } state_e;

  localparam logic DIR_ARRIVE = 1'b0;
  localparam logic DIR_DEPART = 1'b1;

  function automatic logic is_eq_state(input state_e s);
    return (s == EQ1) || (s == EQ2);
  endfunction

endpackage

// File: rtl/airlock_sequencer_phase_timer.sv
// Equalize-phase cycle counter with dwell and timeout comparisons.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : force count to zero (held while not in an equalize phase)
//   en_i          : count one cycle; saturates at all-ones
//   min_i         : minimum dwell in cycles (>= 1)
//   timeout_i     : timeout in cycles (>= 1)
//   cnt_o         : current count
//   min_hit_o     : cnt >= min_i - 1
//   timeout_hit_o : cnt == timeout_i - 1
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] min_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             min_hit_o,
  output logic             timeout_hit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; count saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign min_hit_o     = (cnt_q >= (min_i - CNT_W'(1)));
  assign timeout_hit_o = (cnt_q == (timeout_i - CNT_W'(1)));

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock controller sequencing arrival and departure.
// Arrival:   EQ1=evacuate,   DOOR1=outer, EQ2=pressurize, DOOR2=inner.
// Departure: EQ1=pressurize, DOOR1=inner, EQ2=evacuate,   DOOR2=outer.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   arrive_req, depart_req    : operator requests, sampled only in IDLE
//   pressurized, evacuated    : chamber pressure sensors
//   outer_open, inner_open    : door sensors
//   arriving, departing       : sequence-in-progress flags
//   pump_press, pump_evac     : pump commands
//   outer_unlock, inner_unlock: door unlock commands
//   done                      : one-cycle completion pulse
//   fault                     : latched fault (cleared only by rst)
//   state                     : current state encoding for debug
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int unsigned PRESS_MIN = 8,
  parameter int unsigned EVAC_MIN  = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic       pressurized,
  input  logic       evacuated,
  input  logic       outer_open,
  input  logic       inner_open,
  output logic       arriving,
  output logic       departing,
  output logic       pump_press,
  output logic       pump_evac,
  output logic       outer_unlock,
  output logic       inner_unlock,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   seen_q, seen_d;

  logic arriving_q, arriving_d;
  logic departing_q, departing_d;
  logic pump_press_q, pump_press_d;
  logic pump_evac_q, pump_evac_d;
  logic outer_unlock_q, outer_unlock_d;
  logic inner_unlock_q, inner_unlock_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic             in_eq;
  logic             eq_press;
  logic             eq_sensor;
  logic             door_outer;
  logic             door_sensor;
  logic             active_d;
  logic [CNT_W-1:0] eq_min;
  logic [CNT_W-1:0] cnt;
  logic             min_hit;
  logic             timeout_hit;

  // Phase decode from current state and direction.
  assign in_eq       = is_eq_state(state_q);
  assign eq_press    = (state_q == EQ1) ? (dir_q == DIR_DEPART) : (dir_q == DIR_ARRIVE);
  assign eq_sensor   = eq_press ? pressurized : evacuated;
  assign door_outer  = (state_q == DOOR1) ? (dir_q == DIR_ARRIVE) : (dir_q == DIR_DEPART);
  assign door_sensor = door_outer ? outer_open : inner_open;
  assign eq_min      = eq_press ? CNT_W'(PRESS_MIN) : CNT_W'(EVAC_MIN);

  // Counter is held clear outside EQ, so it reads zero on EQ entry.
  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (!in_eq),
    .en_i         (in_eq),
    .min_i        (eq_min),
    .timeout_i    (CNT_W'(TIMEOUT)),
    .cnt_o        (cnt),
    .min_hit_o    (min_hit),
    .timeout_hit_o(timeout_hit)
  );

  // Next state, and outputs decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    seen_d  = seen_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        if (arrive_req) begin
          state_d = EQ1;
          dir_d   = DIR_ARRIVE;
        end else if (depart_req) begin
          state_d = EQ1;
          dir_d   = DIR_DEPART;
        end
      end
      EQ1, EQ2: begin
        // Fault checks outrank the normal exit.
        if (pressurized && evacuated) begin
          state_d = FAULT;
        end else if (timeout_hit && !eq_sensor) begin
          state_d = FAULT;
        end else if (min_hit && eq_sensor) begin
          state_d = (state_q == EQ1) ? DOOR1 : DOOR2;
        end
      end
      DOOR1, DOOR2: begin
        if (door_sensor) begin
          seen_d = 1'b1;
        end
        // Exit once the door has been seen open and is now closed.
        if (seen_q && !door_sensor) begin
          seen_d = 1'b0;
          if (state_q == DOOR1) begin
            state_d = EQ2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    active_d       = (state_d == EQ1) || (state_d == DOOR1) ||
                     (state_d == EQ2) || (state_d == DOOR2);
    arriving_d     = active_d && (dir_d == DIR_ARRIVE);
    departing_d    = active_d && (dir_d == DIR_DEPART);
    pump_press_d   = ((state_d == EQ1) && (dir_d == DIR_DEPART)) ||
                     ((state_d == EQ2) && (dir_d == DIR_ARRIVE));
    pump_evac_d    = ((state_d == EQ1) && (dir_d == DIR_ARRIVE)) ||
                     ((state_d == EQ2) && (dir_d == DIR_DEPART));
    outer_unlock_d = ((state_d == DOOR1) && (dir_d == DIR_ARRIVE)) ||
                     ((state_d == DOOR2) && (dir_d == DIR_DEPART));
    inner_unlock_d = ((state_d == DOOR1) && (dir_d == DIR_DEPART)) ||
                     ((state_d == DOOR2) && (dir_d == DIR_ARRIVE));
    fault_d        = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dir_q          <= DIR_ARRIVE;
      seen_q         <= 1'b0;
      arriving_q     <= 1'b0;
      departing_q    <= 1'b0;
      pump_press_q   <= 1'b0;
      pump_evac_q    <= 1'b0;
      outer_unlock_q <= 1'b0;
      inner_unlock_q <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      seen_q         <= seen_d;
      arriving_q     <= arriving_d;
      departing_q    <= departing_d;
      pump_press_q   <= pump_press_d;
      pump_evac_q    <= pump_evac_d;
      outer_unlock_q <= outer_unlock_d;
      inner_unlock_q <= inner_unlock_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
    end
  end

  // An equalize phase always leaves by TIMEOUT-1, so the count never passes it.
  always_ff @(posedge clk) begin
    if (!rst && in_eq) begin
      assert (cnt <= CNT_W'(TIMEOUT - 1));
    end
  end

  assign arriving     = arriving_q;
  assign departing    = departing_q;
  assign pump_press   = pump_press_q;
  assign pump_evac    = pump_evac_q;
  assign outer_unlock = outer_unlock_q;
  assign inner_unlock = inner_unlock_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign state        = state_q;

endmodule
